// File: rtl/enc_pkg.sv
// Shared definitions for the serial 8-to-3 priority encoder.
//   state_t : FSM state encoding (IDLE, BUSY)
//   N_IN    : number of request inputs
//   W_CODE  : width of the binary index code
package enc_pkg;
  localparam int N_IN   = 8;
  localparam int W_CODE = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational priority selector over the pending request vector.
//   pend   : pending requests, bit i = request Di
//   idx    : index of the highest-priority set bit (0 when none set)
//   any    : at least one request pending
//   onehot : one-hot mask of the selected bit (all zero when none set)
// MSB_FIRST=0 gives D0 the highest priority; MSB_FIRST=1 gives D7 the highest priority.
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [N_IN-1:0]   pend,
  output logic [W_CODE-1:0] idx,
  output logic              any,
  output logic [N_IN-1:0]   onehot
);

  // Walk from lowest to highest priority; the last hit wins.
  always_comb begin
    idx    = '0;
    onehot = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (MSB_FIRST) begin
        if (pend[i]) begin
          idx       = W_CODE'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end else begin
        if (pend[N_IN-1-i]) begin
          idx              = W_CODE'(N_IN-1-i);
          onehot           = '0;
          onehot[N_IN-1-i] = 1'b1;
        end
      end
    end
  end

  assign any = |pend;

endmodule

// File: rtl/enc8x3_serial.sv
// Serial 8-to-3 priority encoder. A request vector is loaded in IDLE and its
// set bits are then emitted one index per accepted transfer, in priority order.
//   clk, rst_n : clock, asynchronous active-low reset
//   En, d      : load strobe and request vector (d[0] is D0), sampled when in_ready
//   in_ready   : idle, a load is accepted
//   w          : binary index of the presented request
//   out_valid  : w is valid; out_ready accepts it
//   last       : w is the final code of the captured vector
//   cnt        : popcount of the last accepted vector (held, not decremented)
//   zero       : one-cycle pulse after a load with d == 0
module enc8x3_serial
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic [0:N_IN-1]   d,
  output logic              in_ready,
  output logic [W_CODE-1:0] w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              last,
  output logic [3:0]        cnt,
  output logic              zero
);

  function automatic logic [3:0] popcount(input logic [N_IN-1:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < N_IN; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  state_t            state, state_nxt;
  logic [N_IN-1:0]   pend;
  logic [N_IN-1:0]   dvec;
  logic [N_IN-1:0]   sel;
  logic [W_CODE-1:0] idx;
  logic              any;
  logic              single;
  logic              load, xfer;

  // Internal vectors are little-endian: dvec[i] = Di.
  always_comb begin
    dvec = '0;
    for (int i = 0; i < N_IN; i++) dvec[i] = d[i];
  end

  prio_enc8 #(.MSB_FIRST(MSB_FIRST)) u_prio (
    .pend   (pend),
    .idx    (idx),
    .any    (any),
    .onehot (sel)
  );

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign single = any && ((pend & (pend - N_IN'(1))) == '0);

  assign load = (state == IDLE) && En;
  assign xfer = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w         = '0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (En && (dvec != '0)) state_nxt = BUSY;
      end
      BUSY: begin
        out_valid = 1'b1;
        w         = idx;
        last      = single;
        if (out_ready && single) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      cnt   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      zero  <= load && (dvec == '0);
      if (load) begin
        pend <= dvec;
        cnt  <= popcount(dvec);
      end else if (xfer) begin
        pend <= pend & ~sel;
      end
    end
  end

endmodule

// File: tb/tb_enc8x3_serial.sv
// Directed self-checking bench for enc8x3_serial. Two instances share stimulus:
// dut (MSB_FIRST=0) is checked throughout, dut1 (MSB_FIRST=1) on the all-ones vector.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_enc8x3_serial;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       En;
  logic [0:7] d;
  logic       out_ready;
  logic       in_ready, out_valid, last, zero;
  logic [2:0] w;
  logic [3:0] cnt;
  logic       in_ready1, out_valid1, last1, zero1;
  logic [2:0] w1;
  logic [3:0] cnt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  enc8x3_serial #(.MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .En(En), .d(d), .in_ready(in_ready), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .last(last), .cnt(cnt), .zero(zero)
  );

  enc8x3_serial #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .En(En), .d(d), .in_ready(in_ready1), .w(w1),
    .out_valid(out_valid1), .out_ready(out_ready), .last(last1), .cnt(cnt1), .zero(zero1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; En = 1'b0; d = 8'h00; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_w", w, 0);
    chk("rst_last", last, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_zero", zero, 0);

    // Load on the very first edge after release: D5 and D7.
    rst_n = 1'b1; En = 1'b1; d = 8'b0000_0101;
    step(); En = 1'b0;
    chk("d57_valid0", out_valid, 1);
    chk("d57_w0", w, 5);
    chk("d57_last0", last, 0);
    chk("d57_cnt", cnt, 2);
    chk("d57_in_ready_busy", in_ready, 0);
    step();
    chk("d57_w1", w, 7);
    chk("d57_last1", last, 1);
    // Load attempt coincident with the final transfer is not taken.
    En = 1'b1; d = 8'h10;
    step();
    chk("d57_idle_ready", in_ready, 1);
    chk("d57_idle_valid", out_valid, 0);
    chk("d57_cnt_hold", cnt, 2);

    // All ones, both priority orders.
    d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step(); En = 1'b0;
      chk("ff_w_lsb", w, i);
      chk("ff_last_lsb", last, (i == 7));
      chk("ff_w_msb", w1, 7 - i);
      chk("ff_last_msb", last1, (i == 7));
      chk("ff_cnt", cnt, 8);
    end
    step();
    chk("ff_done_ready", in_ready, 1);
    chk("ff_done_valid", out_valid, 0);

    // D3 only, stalled 4 cycles; a load of D0/D7 during BUSY is ignored.
    En = 1'b1; d = 8'h10; out_ready = 1'b0;
    step();
    d = 8'h81;
    for (int j = 0; j < 4; j++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_w", w, 3);
      chk("stall_last", last, 1);
      chk("stall_cnt", cnt, 1);
      if (j < 3) step();
    end
    En = 1'b0; out_ready = 1'b1;
    step();
    chk("stall_done_ready", in_ready, 1);
    chk("stall_done_valid", out_valid, 0);

    // Empty load.
    En = 1'b1; d = 8'h00;
    step(); En = 1'b0;
    chk("zero_pulse", zero, 1);
    chk("zero_cnt", cnt, 0);
    chk("zero_valid", out_valid, 0);
    chk("zero_ready", in_ready, 1);
    step();
    chk("zero_pulse_end", zero, 0);
    chk("zero_valid2", out_valid, 0);

    // D0..D3 loaded, reset after two transfers.
    En = 1'b1; d = 8'hF0;
    step(); En = 1'b0;
    chk("f0_w0", w, 0);
    chk("f0_cnt", cnt, 4);
    step();
    chk("f0_w1", w, 1);
    step();
    chk("f0_w2", w, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_ready", in_ready, 1);
    step(); rst_n = 1'b1;
    step();
    chk("post_rst_valid_a", out_valid, 0);
    step();
    chk("post_rst_valid_b", out_valid, 0);
    chk("post_rst_w", w, 0);
    En = 1'b1; d = 8'h02;
    step(); En = 1'b0;
    chk("d6_w", w, 6);
    chk("d6_last", last, 1);
    chk("d6_cnt", cnt, 1);
    step();
    chk("d6_done_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/enc8x3_serial.md
ENC8X3_SERIAL -- requirements
Module: enc8x3_serial

Interface
REQ-001 Parameter: MSB_FIRST, default 0; 0 means D0 is highest priority, 1 means D7 is highest priority.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 En  input  1  load strobe; samples d when in_ready=1.
REQ-005 d  input  [0:7]  request vector; d[0] is D0 and d[7] is D7.
REQ-006 in_ready  output  1  block is idle and accepts a load.
REQ-007 w  output  [2:0]  binary code of the currently presented request index.
REQ-008 out_valid  output  1  w is valid.
REQ-009 out_ready  input  1  consumer accepts w.
REQ-010 last  output  1  w is the final code of the captured vector.
REQ-011 cnt  output  [3:0]  popcount of the captured vector, range 0..8.
REQ-012 zero  output  1  one-cycle pulse when a load with d=0 is accepted.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-014 In IDLE: in_ready=1, out_valid=0, w=3'b000, last=0.
REQ-015 In IDLE with En=1 and d!=0: capture d into pend, load cnt with popcount(d), and enter BUSY on the same edge.
REQ-016 Latency: out_valid SHALL assert in the first cycle after the accepting edge.
REQ-017 In IDLE with En=1 and d=0: stay in IDLE, set cnt=0, and assert zero for exactly one cycle.
REQ-018 In BUSY: in_ready=0, En and d ignored, out_valid=1.
REQ-019 In BUSY: w = index of the highest-priority set bit of pend, per MSB_FIRST.
REQ-020 In BUSY: last=1 iff pend has exactly one bit set.
REQ-021 Handshake: transfer occurs iff out_valid=1 and out_ready=1 at a rising edge; on transfer, clear the presented bit in pend.
REQ-022 On a transfer with last=1: return to IDLE; in_ready=1 in the next cycle.
REQ-023 A load SHALL NOT be accepted in the same cycle as the final transfer.
REQ-024 Stall: while out_valid=1 and out_ready=0, w, last and pend SHALL hold stable.
REQ-025 Throughput: one code per cycle while out_ready=1; a vector with k bits set completes in k BUSY cycles.
REQ-026 cnt SHALL hold its captured value until the next accepted load; it is not decremented.
REQ-027 cnt SHALL be 4 bits wide with no truncation; d=8'hFF gives cnt=4'd8.

Reset
REQ-028 When rst_n=0, asynchronously force: state=IDLE, pend=0, cnt=0, zero=0, out_valid=0, w=3'b000, last=0, in_ready=1.
REQ-029 Reset asserted mid-BUSY SHALL discard all pending codes; no code is emitted after reset release until a new load is accepted.
REQ-030 The first load SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package (enc_pkg) SHALL hold: the state type (IDLE, BUSY), N_IN=8, and W_CODE=3.
REQ-032 A single combinational sub-module, prio_enc8 (pend and MSB_FIRST in; index, any and onehot-of-index out), SHALL perform priority selection.
REQ-033 Popcount and FSM logic SHALL reside in enc8x3_serial.

Verification
REQ-034 Reset, then En=1 with d=8'b0000_0101 (D5, D7 set), out_ready=1 -> w=5 with last=0, then w=7 with last=1, cnt=2, in_ready=1 the following cycle.
REQ-035 d=8'hFF with out_ready=1 -> w=0,1,...,7 on consecutive cycles, last only on w=7, cnt=8; with MSB_FIRST=1 -> w=7 down to 0.
REQ-036 Load D3 only, hold out_ready=0 for 4 cycles -> w=3, last=1 stable all 4 cycles; release out_ready -> one transfer, then IDLE.
REQ-037 En=1 with d=0 in IDLE -> zero pulses for 1 cycle, cnt=0, out_valid stays 0; En=1 with d=8'h81 during BUSY -> ignored, pend unchanged.
REQ-038 Load 8'hF0, drop rst_n after 2 transfers -> out_valid=0 immediately and cnt=0; after release, no stale codes; a new load of D6 -> w=6, last=1.
